// File: rtl/rr_mux_reg.sv
// N_CH-way request merger: round-robin or fixed-priority arbitration feeding a
// one-deep registered output stage with a valid/ready handshake to one consumer.
module rr_mux_reg #(
  parameter int NB        = 32,
  parameter int N_CH      = 4,
  parameter int NB_SELECT = 2,
  parameter int MODE      = 0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [N_CH-1:0]      i_valid,
  input  logic [N_CH*NB-1:0]   i_data,
  output logic [N_CH-1:0]      o_ready,
  output logic                 o_valid,
  output logic [NB-1:0]        o_data,
  output logic [NB_SELECT-1:0] o_sel,
  input  logic                 i_ready
);

  logic                 valid_q, valid_d;
  logic [NB-1:0]        data_q, data_d;
  logic [NB_SELECT-1:0] sel_q, sel_d;
  logic [NB_SELECT-1:0] ptr_q, ptr_d;

  logic                 load_en;
  logic                 win_found;
  logic [NB_SELECT-1:0] win_idx;
  logic [NB-1:0]        win_data;
  logic [NB_SELECT-1:0] next_ptr;

  assign load_en = !valid_q || i_ready;

  // Fixed priority is the rotating search with its start pinned at channel 0.
  always_comb begin
    int base;
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    base      = (MODE == 1) ? 0 : int'(ptr_q);
    idx       = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = base + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!win_found && i_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = NB_SELECT'(idx);
      end
    end
  end

  assign win_data = i_data[int'(win_idx)*NB +: NB];
  assign next_ptr = (int'(win_idx) == N_CH - 1) ? '0 : win_idx + NB_SELECT'(1);

  assign o_ready = (load_en && win_found && !i_reset) ? (N_CH'(1) << win_idx) : '0;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      valid_d = win_found;
      if (win_found) begin
        data_d = win_data;
        sel_d  = win_idx;
        if (MODE == 0) ptr_d = next_ptr;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg: a round-robin and a fixed-priority instance share stimulus;
// a reference model queues expected words at acceptance and compares at output.
module tb_rr_mux_reg;

  localparam int NB = 32;
  localparam int N  = 4;
  localparam int NS = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    valid;
  logic [N*NB-1:0] data;
  logic            rdy_in;

  logic [N-1:0]    rdy0, rdy1;
  logic            ov0, ov1;
  logic [NB-1:0]   od0, od1;
  logic [NS-1:0]   os0, os1;

  always #5 clk = ~clk;

  rr_mux_reg #(.NB(NB), .N_CH(N), .NB_SELECT(NS), .MODE(0)) dut0 (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_data(data),
    .o_ready(rdy0), .o_valid(ov0), .o_data(od0), .o_sel(os0), .i_ready(rdy_in));

  rr_mux_reg #(.NB(NB), .N_CH(N), .NB_SELECT(NS), .MODE(1)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_data(data),
    .o_ready(rdy1), .o_valid(ov1), .o_data(od1), .o_sel(os1), .i_ready(rdy_in));

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state (per instance)
  int            m_ptr;
  logic          m_v0, m_v1;
  logic [NB-1:0] m_d0, m_d1;
  logic [NS-1:0] m_s0, m_s1;
  logic [NS+NB-1:0] q0[$];
  logic [NS+NB-1:0] q1[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int arb(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [NB-1:0] chan(input int k);
    return data[k*NB +: NB];
  endfunction

  task automatic set_data(input logic [NB-1:0] base);
    for (int k = 0; k < N; k++) data[k*NB +: NB] = base | NB'(k);
  endtask

  // One clock: check combinational ready before the edge, registers after it.
  task automatic step();
    logic le0, le1;
    int w0, w1;
    logic [NS+NB-1:0] e;
    @(negedge clk);
    if (rst) begin
      check("rdy0_rst", 64'(rdy0), 64'd0);
      check("rdy1_rst", 64'(rdy1), 64'd0);
      @(posedge clk); #1;
      m_ptr = 0; m_v0 = 0; m_v1 = 0; m_d0 = '0; m_d1 = '0; m_s0 = '0; m_s1 = '0;
      q0.delete(); q1.delete();
      check("v0_rst", 64'(ov0), 64'd0);
      check("d0_rst", 64'(od0), 64'd0);
      check("s0_rst", 64'(os0), 64'd0);
      check("v1_rst", 64'(ov1), 64'd0);
      check("d1_rst", 64'(od1), 64'd0);
      return;
    end
    le0 = !m_v0 || rdy_in;
    le1 = !m_v1 || rdy_in;
    w0  = arb(valid, m_ptr);
    w1  = arb(valid, 0);
    check("rdy0", 64'(rdy0), (le0 && w0 >= 0) ? (64'd1 << w0) : 64'd0);
    check("rdy1", 64'(rdy1), (le1 && w1 >= 0) ? (64'd1 << w1) : 64'd0);
    if (le0 && w0 >= 0) begin
      q0.push_back({NS'(w0), chan(w0)});
      m_ptr = (w0 + 1) % N;
    end
    if (le1 && w1 >= 0) q1.push_back({NS'(w1), chan(w1)});
    @(posedge clk); #1;
    if (le0) begin
      m_v0 = (w0 >= 0);
      if (w0 >= 0) begin
        e = q0.pop_front();
        m_s0 = e[NS+NB-1:NB];
        m_d0 = e[NB-1:0];
      end
    end
    if (le1) begin
      m_v1 = (w1 >= 0);
      if (w1 >= 0) begin
        e = q1.pop_front();
        m_s1 = e[NS+NB-1:NB];
        m_d1 = e[NB-1:0];
      end
    end
    check("v0", 64'(ov0), 64'(m_v0));
    check("s0", 64'(os0), 64'(m_s0));
    check("d0", 64'(od0), 64'(m_d0));
    check("v1", 64'(ov1), 64'(m_v1));
    check("s1", 64'(os1), 64'(m_s1));
    check("d1", 64'(od1), 64'(m_d1));
  endtask

  initial begin
    m_ptr = 0; m_v0 = 0; m_v1 = 0; m_d0 = '0; m_d1 = '0; m_s0 = '0; m_s1 = '0;
    rst = 1'b1; valid = 4'b1111; rdy_in = 1'b1;
    set_data(32'hA000_0000);

    // Reset with all channels requesting
    step(); step();

    // Round-robin rotation under full load
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_seq", 64'(os0), 64'(i % 4));
      check("rr_data", 64'(od0), 64'(32'hA000_0000 | (i % 4)));
      check("fp_all", 64'(os1), 64'd0);
    end

    // Fixed priority with channels 1 and 2 requesting
    valid = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fp_sel", 64'(os1), 64'd1);
    end

    // Backpressure while holding channel 2's word
    rst = 1'b1; step(); rst = 1'b0;
    data[2*NB +: NB] = 32'h1234_5678;
    valid = 4'b0100; step();
    check("bp_load", 64'(od0), 64'h1234_5678);
    valid = 4'b1111; rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold", 64'(od0), 64'h1234_5678);
      check("bp_sel", 64'(os0), 64'd2);
    end
    rdy_in = 1'b1; step();
    check("bp_next", 64'(os0), 64'd3);

    // Single word then drain; pointer resumes at channel 2
    rst = 1'b1; step(); rst = 1'b0;
    set_data(32'hA000_0000);
    valid = 4'b0010; step();
    check("drain_v1", 64'(ov0), 64'd1);
    valid = 4'b0000; step();
    check("drain_v0", 64'(ov0), 64'd0);
    valid = 4'b0111; step();
    check("drain_ptr", 64'(os0), 64'd2);

    // Reset during a stall
    valid = 4'b1111; rdy_in = 1'b1; step();
    rdy_in = 1'b0; step();
    check("stall_v", 64'(ov0), 64'd1);
    rst = 1'b1; step(); rst = 1'b0;
    rdy_in = 1'b1; step();
    check("rst_ptr", 64'(os0), 64'd0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      valid  = 4'($urandom_range(0, 15));
      rdy_in = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) data[k*NB +: NB] = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised successor of the 4-way datapath select mux: N_CH-input, NB-bit selector with a registered output stage and a valid/ready handshake.
- Selection is by internal arbitration, not a static select, in either round-robin or fixed-priority mode.
- Merges multiple requesters (pipeline-stage writeback sources, debug-unit/memory access ports) onto one shared consumer.
- One-deep output register holds data while the consumer stalls.

Parameters:
- NB, 32, data width of each channel and of the output.
- N_CH, 4, number of input channels, 2 to 16.
- NB_SELECT, 2, width of the granted-channel index; must equal ceil(log2(N_CH)).
- MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- i_clock  in  1  system clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  N_CH  per-channel request; bit k means channel k offers data.
- i_data  in  N_CH*NB  packed channel data; channel k occupies bits [k*NB +: NB].
- o_ready  out  N_CH  one-hot accept; bit k high means channel k's word is taken this cycle.
- o_valid  out  1  output register holds a valid word.
- o_data  out  NB  registered selected data.
- o_sel  out  NB_SELECT  index of the channel whose word is in o_data.
- i_ready  in  1  consumer accepts o_data this cycle when o_valid=1.

Behaviour:
- Reset:
  - Synchronous: the clock edge with i_reset=1 sets o_valid=0, o_data=0, o_sel=0, round-robin pointer=0.
  - o_ready=0 while i_reset=1.
  - Reset mid-operation discards any held word; no o_ready pulse in that cycle.
- Load condition:
  - load_en = (!o_valid) | (o_valid & i_ready).
  - o_ready is combinational: o_ready[w]=1 only when load_en=1 and w is the winner.
  - Otherwise o_ready is all zeros.
  - Channel k counts as transferred in any cycle where i_valid[k] & o_ready[k].
- Arbitration, combinational, evaluated every cycle among i_valid bits:
  - MODE=1: winner = lowest index k with i_valid[k]=1.
  - MODE=0: search starts at the pointer p and wraps at N_CH-1 -> 0; winner = first requesting index.
  - MODE=0 pointer update: after a load from channel w, p becomes (w+1) mod N_CH. The pointer is unchanged when no load occurs.
  - MODE=1 keeps no pointer state.
- Output register, on the clock edge with load_en=1:
  - If any i_valid: o_data = channel w data, o_sel = w, o_valid=1.
  - If no request: o_valid=0. o_data and o_sel hold their previous values (don't-care, but not X).
- Stall: with o_valid=1 and i_ready=0, o_data, o_sel and o_valid hold and o_ready=0. No request is lost because sources hold i_valid.
- Throughput and latency:
  - Full throughput: a new word every cycle while i_ready=1 and requests are present.
  - Latency from acceptance to o_valid is 1 cycle.
- Boundary conditions:
  - All channels requesting in MODE=0: grants rotate 0,1,2,3,0,... with no channel starved more than N_CH-1 loads.
  - A single requester is granted every load cycle.
  - i_ready with o_valid=0 is ignored.
  - A request dropped while not accepted is simply not considered; no state is kept per channel.
  - The pointer wraps at N_CH-1 -> 0, including for N_CH not a power of 2: indices >= N_CH are never selected.

Test Plan:
- Reset check: i_reset=1 for 2 cycles with all i_valid=1 -> o_valid=0, o_data=0, o_sel=0, o_ready=0000. On release, the first load grants channel 0.
- Round-robin fairness: MODE=0, N_CH=4, i_valid=1111, data k=0xA000000k, i_ready=1 for 8 cycles -> o_sel sequence 0,1,2,3,0,1,2,3 with matching o_data; o_ready one-hot each cycle.
- Fixed priority: MODE=1, i_valid=0110 constantly, i_ready=1 -> o_sel=1 every cycle, o_ready=0010; channel 2 never granted.
- Backpressure: o_valid=1 holding 0x12345678 from channel 2, i_ready=0 for 3 cycles with i_valid=1111 -> o_data, o_sel hold and o_ready=0000. On i_ready=1, the next grant is channel 3 in MODE=0.
- Idle and drain: single word from channel 1 then i_valid=0000 with i_ready=1 -> o_valid high for exactly 1 cycle, then 0; pointer=2, so the next simultaneous request 0111 grants channel 2.
- Reset mid-stall: o_valid=1, i_ready=0, assert i_reset one cycle -> o_valid=0, o_data=0, pointer=0 next cycle; no o_ready pulse in the reset cycle.
